// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS core:
//   - npc_sel_e   : next-PC source encoding driven by decode
//   - PC_RESET_VAL: PC value after reset
//   - NOP_INSTR   : instruction word loaded into F/D on flush / reset
//   - branchOffset: sign-extended, word-scaled branch displacement
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  // Next-PC source selected by the instruction currently in D
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Branch displacement: sext(imm16) << 2
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_npc.sv
// ---------------------------------------------------------------------------
// fetch_npc
// Purely combinational next-PC selection for the fetch stage.
// Ports:
//   i_pcF      : current fetch PC
//   i_pcD      : PC of the instruction in D
//   i_irIndex  : IR_D[25:0] (jump index; low 16 bits are the branch immediate)
//   i_npcSel   : next-PC source (npc_sel_e encoding)
//   i_brTaken  : branch comparison result for the instruction in D
//   i_rsFwd    : forwarded rs value, jr/jalr target
//   o_npc      : next PC (32-bit wrap-around arithmetic)
// ---------------------------------------------------------------------------
module fetch_npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] i_pcF,
  input  logic [31:0] i_pcD,
  input  logic [25:0] i_irIndex,
  input  logic [1:0]  i_npcSel,
  input  logic        i_brTaken,
  input  logic [31:0] i_rsFwd,
  output logic [31:0] o_npc
);

  logic [31:0] w_pcF4;
  logic [31:0] w_brTarget;
  logic [31:0] w_jTarget;

  // The delay slot is already in F, so a branch target is relative to PC_D+4
  assign w_pcF4     = i_pcF + 32'd4;
  assign w_brTarget = i_pcD + 32'd4 + branchOffset(i_irIndex[15:0]);
  assign w_jTarget  = {i_pcD[31:28], i_irIndex, 2'b00};

  // Source mux; a not-taken branch falls through to the sequential PC
  always_comb begin
    o_npc = w_pcF4;
    case (npc_sel_e'(i_npcSel))
      NPC_SEQ: o_npc = w_pcF4;
      NPC_BR:  o_npc = i_brTaken ? w_brTarget : w_pcF4;
      NPC_J:   o_npc = w_jTarget;
      NPC_JR:  o_npc = i_rsFwd;
      default: o_npc = w_pcF4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus the F/D pipeline register of the MIPS core.
// Holds the PC, selects the next PC (via fetch_npc) from the instruction
// resolved in D, drives instruction memory and feeds decode.
//
// Parameters:
//   PC_RESET   : PC after reset
//   IMEM_BASE  : byte address of imem word 0   (FETCH_ADEL_EN builds only)
//   IMEM_WORDS : imem depth in words           (FETCH_ADEL_EN builds only)
//
// Ports:
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   pc_en, D_en  : PC / F/D load enables from the stall controller
//   d_clr        : F/D flush, loads a NOP
//   npc_sel      : next-PC source for the instruction in D
//   br_taken     : branch outcome for the instruction in D
//   rs_fwd_D     : forwarded rs value, jr target
//   imem_addr    : fetch byte address (= PC_F)
//   imem_rdata   : combinational instruction word at imem_addr
//   PC_F         : current fetch PC
//   IR_D, PC_D   : instruction and its PC in D
//   PC8_D        : PC_D + 8, jal/jalr link value
//   exc_adel_D   : fetch address-error flag in D (FETCH_ADEL_EN only)
//
// Build option: define FETCH_ADEL_EN to flag misaligned or out-of-range
// fetches; otherwise imem_rdata passes through unchanged.
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_VAL
`ifdef FETCH_ADEL_EN
  ,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
`endif
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_en,
  input  logic        D_en,
  input  logic        d_clr,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_fwd_D,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D
`ifdef FETCH_ADEL_EN
  ,
  output logic        exc_adel_D
`endif
);

  logic [31:0] r_pcF;
  logic [31:0] r_irD;
  logic [31:0] r_pcD;
  logic [31:0] r_pc8D;
  logic [31:0] w_npc;
  logic [31:0] w_fetchWord;

  fetch_npc u_npc (
    .i_pcF     (r_pcF),
    .i_pcD     (r_pcD),
    .i_irIndex (r_irD[25:0]),
    .i_npcSel  (npc_sel),
    .i_brTaken (br_taken),
    .i_rsFwd   (rs_fwd_D),
    .o_npc     (w_npc)
  );

`ifdef FETCH_ADEL_EN
  // End of the valid fetch window, computed in 33 bits so it cannot wrap
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  logic w_fetchFault;
  logic r_adelD;

  assign w_fetchFault = (r_pcF[1:0] != 2'b00) ||
                        (r_pcF < IMEM_BASE) ||
                        ({1'b0, r_pcF} >= IMEM_END);
  assign w_fetchWord  = w_fetchFault ? NOP_INSTR : imem_rdata;

  // Fault flag travels with IR_D; reset and flush both clear it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adelD <= 1'b0;
    end else if (D_en) begin
      r_adelD <= !d_clr && w_fetchFault;
    end
  end

  assign exc_adel_D = r_adelD;
`else
  assign w_fetchWord = imem_rdata;
`endif

  // PC register: a stall wins over any redirect, since the branch in D may
  // be waiting on operands that are not yet valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcF <= PC_RESET;
    end else if (pc_en) begin
      r_pcF <= w_npc;
    end
  end

  // F/D register: while held, the fetched word is dropped and refetched
  // from the held PC on the next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irD  <= NOP_INSTR;
      r_pcD  <= PC_RESET;
      r_pc8D <= PC_RESET + 32'd8;
    end else if (D_en) begin
      r_irD  <= d_clr ? NOP_INSTR : w_fetchWord;
      r_pcD  <= r_pcF;
      r_pc8D <= r_pcF + 32'd8;
    end
  end

  assign imem_addr = r_pcF;
  assign PC_F      = r_pcF;
  assign IR_D      = r_irD;
  assign PC_D      = r_pcD;
  assign PC8_D     = r_pc8D;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A small instruction-memory model
// answers imem_addr combinationally; a vector table walks sequential fetch,
// branches (taken / not taken / backward), jal, jr under stall, flush and
// 32-bit wrap, then hand-written sequences cover asynchronous reset
// mid-stall and the misaligned-fetch behaviour of the current build.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        pc_en;
  logic        D_en;
  logic        d_clr;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] rs_fwd_D;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
`ifdef FETCH_ADEL_EN
  logic        exc_adel_D;
`endif

  fetch_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_en      (pc_en),
    .D_en       (D_en),
    .d_clr      (d_clr),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .rs_fwd_D   (rs_fwd_D),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .PC_F       (PC_F),
    .IR_D       (IR_D),
    .PC_D       (PC_D),
    .PC8_D      (PC8_D)
`ifdef FETCH_ADEL_EN
    ,
    .exc_adel_D (exc_adel_D)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: 128 words at 0x3000, zero elsewhere
  logic [31:0] mem [0:127];
  logic [31:0] imemOffset;

  always_comb begin
    imemOffset = imem_addr - 32'h0000_3000;
    imem_rdata = 32'h0;
    if (imem_addr >= 32'h0000_3000 && imemOffset < 32'd512)
      imem_rdata = mem[imemOffset[8:2]];
  end

  typedef struct {
    logic        pcEn;
    logic        dEn;
    logic        dClr;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] rs;
    logic [31:0] ePcF;
    logic [31:0] eIrD;
    logic [31:0] ePcD;
    logic [31:0] ePc8D;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] pcF;
    logic [31:0] irD;
    logic [31:0] pcD;
    logic [31:0] pc8D;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compareCount = 0;
  int   failCount    = 0;

  task automatic compareWord(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs and record what the outputs must be after the edge
  task automatic applyStimulus(input string tag, input logic pcEn, input logic dEn,
                               input logic dClr, input logic [1:0] sel, input logic br,
                               input logic [31:0] rs, input logic [31:0] ePcF,
                               input logic [31:0] eIrD, input logic [31:0] ePcD,
                               input logic [31:0] ePc8D);
    exp_t e;
    pc_en    = pcEn;
    D_en     = dEn;
    d_clr    = dClr;
    npc_sel  = sel;
    br_taken = br;
    rs_fwd_D = rs;
    e.tag  = tag;
    e.pcF  = ePcF;
    e.irD  = eIrD;
    e.pcD  = ePcD;
    e.pc8D = ePc8D;
    sb.push_back(e);
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] ePcF, input logic [31:0] eIrD,
                            input logic [31:0] ePcD, input logic [31:0] ePc8D);
    exp_t e;
    e.tag  = tag;
    e.pcF  = ePcF;
    e.irD  = eIrD;
    e.pcD  = ePcD;
    e.pc8D = ePc8D;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      compareWord({e.tag, ".PC_F"},  PC_F,  e.pcF);
      compareWord({e.tag, ".IR_D"},  IR_D,  e.irD);
      compareWord({e.tag, ".PC_D"},  PC_D,  e.pcD);
      compareWord({e.tag, ".PC8_D"}, PC8_D, e.pc8D);
      compareWord({e.tag, ".imem_addr"}, imem_addr, e.pcF);
    end
  endtask

  task automatic stepAndCheck();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

`ifdef FETCH_ADEL_EN
  task automatic checkExc(input string tag, input logic exp);
    compareWord({tag, ".exc_adel_D"}, {31'b0, exc_adel_D}, {31'b0, exp});
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[1]    = 32'h1000_0003;  // 3004 beq $0,$0,+3
    mem[2]    = 32'h2401_0008;  // 3008 delay slot
    mem[3]    = 32'h2402_000C;  // 300C
    mem[4]    = 32'h0C00_0C01;  // 3010 jal 0x3004
    mem[5]    = 32'h2403_0014;  // 3014
    mem[6]    = 32'h2404_0018;  // 3018
    mem[64]   = 32'h2405_3100;  // 3100
    mem[65]   = 32'h2406_3104;  // 3104
    mem[66]   = 32'h1000_FFFC;  // 3108 beq backward -4

    // pcEn dEn dClr sel br rs | PC_F IR_D PC_D PC8_D
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3004,32'h0,        32'h3000,32'h3008});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3008,32'h1000_0003,32'h3004,32'h300C});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b01,1'b1,32'h0,    32'h3014,32'h2401_0008,32'h3008,32'h3010});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3018,32'h2403_0014,32'h3014,32'h301C});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b11,1'b0,32'h3004, 32'h3004,32'h2404_0018,32'h3018,32'h3020});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3008,32'h1000_0003,32'h3004,32'h300C});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b01,1'b0,32'h0,    32'h300C,32'h2401_0008,32'h3008,32'h3010});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3010,32'h2402_000C,32'h300C,32'h3014});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3014,32'h0C00_0C01,32'h3010,32'h3018});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b10,1'b0,32'h0,    32'h3004,32'h2403_0014,32'h3014,32'h301C});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3008,32'h1000_0003,32'h3004,32'h300C});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b11,1'b0,32'h3100, 32'h3008,32'h1000_0003,32'h3004,32'h300C});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b11,1'b0,32'h3100, 32'h3008,32'h1000_0003,32'h3004,32'h300C});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b11,1'b0,32'h3100, 32'h3100,32'h2401_0008,32'h3008,32'h3010});
    vecs.push_back('{1'b1,1'b1,1'b1,2'b00,1'b0,32'h0,    32'h3104,32'h0,        32'h3100,32'h3108});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3108,32'h2406_3104,32'h3104,32'h310C});
    vecs.push_back('{1'b0,1'b0,1'b1,2'b00,1'b0,32'h0,    32'h3108,32'h2406_3104,32'h3104,32'h310C});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h310C,32'h1000_FFFC,32'h3108,32'h3110});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b01,1'b1,32'h0,    32'h30FC,32'h0,        32'h310C,32'h3114});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h3100,32'h0,        32'h30FC,32'h3104});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b11,1'b0,32'hFFFF_FFFC, 32'hFFFF_FFFC,32'h2405_3100,32'h3100,32'h3108});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,    32'h0000_0000,32'h0,   32'hFFFF_FFFC,32'h0000_0004});
    vecs.push_back('{1'b1,1'b1,1'b0,2'b10,1'b0,32'h0,    32'hF000_0000,32'h0,   32'h0000_0000,32'h0000_0008});

    reset_n  = 1'b0;
    pc_en    = 1'b0;
    D_en     = 1'b0;
    d_clr    = 1'b0;
    npc_sel  = 2'b00;
    br_taken = 1'b0;
    rs_fwd_D = 32'h0;

    #12;
    pushExpect("reset", 32'h3000, 32'h0, 32'h3000, 32'h3008);
    checkOutput();
`ifdef FETCH_ADEL_EN
    checkExc("reset", 1'b0);
`endif
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].pcEn, vecs[i].dEn, vecs[i].dClr,
                    vecs[i].sel, vecs[i].br, vecs[i].rs, vecs[i].ePcF,
                    vecs[i].eIrD, vecs[i].ePcD, vecs[i].ePc8D);
      stepAndCheck();
    end

    // Stall, then assert reset between edges: outputs must change at once
    applyStimulus("stall", 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h3100,
                  32'hF000_0000, 32'h0, 32'h0, 32'h8);
    stepAndCheck();
    #3;
    reset_n = 1'b0;
    #1;
    pushExpect("asyncReset", 32'h3000, 32'h0, 32'h3000, 32'h3008);
    checkOutput();
    @(posedge clk);
    #1;
    pushExpect("resetHeld", 32'h3000, 32'h0, 32'h3000, 32'h3008);
    checkOutput();
    #2;
    reset_n = 1'b1;
    applyStimulus("release", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  32'h3000, 32'h0, 32'h3000, 32'h3008);
    #1;
    checkOutput();
    applyStimulus("firstEdge", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  32'h3004, 32'h0, 32'h3000, 32'h3008);
    stepAndCheck();

    // Misaligned jr target 0x3102
    applyStimulus("jrMis", 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3102,
                  32'h3102, 32'h1000_0003, 32'h3004, 32'h300C);
    stepAndCheck();
`ifdef FETCH_ADEL_EN
    applyStimulus("adelMis", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  32'h3106, 32'h0, 32'h3102, 32'h310A);
    stepAndCheck();
    checkExc("adelMis", 1'b1);
    applyStimulus("adelLast", 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h6FFC,
                  32'h6FFC, 32'h0, 32'h3106, 32'h310E);
    stepAndCheck();
    checkExc("adelLast", 1'b1);
    applyStimulus("adelInRange", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  32'h7000, 32'h0, 32'h6FFC, 32'h7004);
    stepAndCheck();
    checkExc("adelInRange", 1'b0);
    applyStimulus("adelEnd", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  32'h7004, 32'h0, 32'h7000, 32'h7008);
    stepAndCheck();
    checkExc("adelEnd", 1'b1);
    applyStimulus("adelClr", 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0,
                  32'h7008, 32'h0, 32'h7004, 32'h700C);
    stepAndCheck();
    checkExc("adelClr", 1'b0);
`else
    applyStimulus("misPass", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  32'h3106, 32'h2405_3100, 32'h3102, 32'h310A);
    stepAndCheck();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
